shift_mac_fir: RTL and testbench
================================

# shift_mac_fir

Parametrised, time-multiplexed FIR multiply-accumulate engine: the next generation of the fixed 16-bit `shift_mac_l1`. It keeps a TAPS-deep sample delay line and a programmable signed coefficient bank, and evaluates one filter output per accepted sample using a single shared multiplier over TAPS cycles. Ready/valid handshakes on input and output let it sit between streaming producer and consumer stages in the signal-processing datapath.

## Interface
- `DATA_W`, 16: signed sample, coefficient and output width.
- `TAPS`, 4: delay-line depth and coefficient count, minimum 2.
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before output.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in DATA_W: signed input sample.
- `in_valid` in 1: sample offered.
- `in_ready` out 1: sample accepted when `in_valid && in_ready`.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in clog2(TAPS): coefficient index, 0 = newest sample.
- `coef_data` in DATA_W: signed coefficient.
- `busy` out 1: high while not IDLE; coefficient writes are dropped while high.
- `out_data` out DATA_W: signed filter result.
- `out_valid` out 1: result held until taken.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: `in_ready = !out_valid || out_ready`. On accept, shift the delay line (x[0] <= in_data, x[k] <= x[k-1]), clear the accumulator and tap index, then go to ACC.
- ACC: each cycle, acc += x[i]*c[i] and i++. After i = TAPS-1, go to DONE. Takes exactly TAPS cycles.
- DONE: out_data <= f(acc >>> SHIFT), out_valid <= 1, then go to IDLE. Takes one cycle.
- Arithmetic: products are signed 2·DATA_W; ACC_W = 2·DATA_W + clog2(TAPS). The shift is arithmetic. f is the saturation or wrap behaviour defined under Configuration.
- Output handshake: out_valid clears on `out_valid && out_ready` unless DONE sets it in the same cycle, in which case it stays set.
- Coefficient write: c[coef_addr] <= coef_data only when `coef_we && !busy`. Writes with `busy` high are silently dropped. A write in the same cycle as a sample accept is applied, and that sample's computation uses the new value.
- `coef_addr` ≥ TAPS: the write is ignored.
- Reset, including mid-ACC: state goes to IDLE and the accumulator, delay line and coefficients clear to 0. Outputs after reset: out_valid=0, out_data=0, busy=0, in_ready=1. A partial result is discarded and never emitted.

## Timing
- Accept edge at cycle t, ACC during t+1..t+TAPS, DONE at t+TAPS+1. out_valid is high from cycle t+TAPS+2.
- Input-to-output latency is TAPS+2 cycles.
- Maximum throughput is one sample per TAPS+2 cycles. The next sample is accepted in the first cycle back in IDLE if `out_ready` is high.
- Backpressure: while out_valid is held high with out_ready low, in_ready stays 0 and no sample is lost.
- in_ready is combinational from state, out_valid and out_ready. All other outputs are registered.

## Configuration
- `SHIFT_MAC_SAT_EN` defined: f clamps the shifted accumulator to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- `SHIFT_MAC_SAT_EN` undefined: f takes the low DATA_W bits of the shifted accumulator (two's-complement wrap), which matches the legacy block's behaviour.

## Structure
- Package `shift_mac_pkg`: the FSM state enum (IDLE/ACC/DONE) and an ACC_W helper function.
- Sub-module `shift_mac_tapline`: the DATA_W × TAPS shift register with shift enable, async active-low clear and an indexed read port. The top level holds the FSM, coefficient bank, multiplier, accumulator and output stage.

## Test plan
- Coefficients [1,2,3,4]; samples 100, 10, 30, 21 with out_ready=1 -> outputs 100, 210, 350, 511, each TAPS+2=6 cycles after its accept.
- Coefficients all 32767; five samples of 32767 -> with SAT_EN, outputs 32767,... all saturated. Without SAT_EN, the fourth output is 0x0004 (low bits of 0xFFFC0004).
- Coefficients [-1,0,0,0], SHIFT=1; sample 101 -> out_data -51 (arithmetic shift).
- out_ready held 0 for 20 cycles after the first result, in_valid high -> in_ready stays 0, out_data stays stable, and the second sample is accepted the cycle out_ready rises.
- coef_we asserted during ACC with addr 0, data 9 -> the write is dropped, the current and next results use the old c[0], and a write in IDLE takes effect.
- rst_n pulsed low in the middle of ACC -> out_valid=0, out_data=0, busy=0 and in_ready=1 immediately. No result is emitted. After reset the coefficients are 0, so the next output is 0.

Source files
------------

// File: rtl/shift_mac_pkg.sv
// Shared types and sizing helpers for the shift_mac_fir engine.
package shift_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Accumulator width: full signed product plus growth for TAPS additions.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned taps);
        return 2 * data_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/shift_mac_tapline.sv
// Sample delay line: TAPS words of DATA_W, shifted on enable, with an indexed read port.
module shift_mac_tapline
    import shift_mac_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAPS   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_shift_en,
    input  logic [DATA_W-1:0]          i_data,
    input  logic [$clog2(TAPS)-1:0]    i_rd_idx,
    output logic [DATA_W-1:0]          o_rd_data
);

    logic [DATA_W-1:0] r_taps [TAPS];

    // Newest sample lands in slot 0; older samples move up one slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                r_taps[k] <= '0;
            end
        end else if (i_shift_en) begin
            r_taps[0] <= i_data;
            for (int unsigned k = 1; k < TAPS; k++) begin
                r_taps[k] <= r_taps[k-1];
            end
        end
    end

    assign o_rd_data = r_taps[i_rd_idx];

endmodule

// File: rtl/shift_mac_fir.sv
// Time-multiplexed FIR MAC: one output per accepted sample over TAPS cycles.
// Define SHIFT_MAC_SAT_EN to saturate the output; otherwise it wraps to DATA_W bits.
module shift_mac_fir
    import shift_mac_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAPS   = 4,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [DATA_W-1:0]          coef_data,
    output logic                       busy,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int unsigned IDX_W  = $clog2(TAPS);
    localparam int unsigned ACC_W  = acc_w(DATA_W, TAPS);
    localparam int unsigned PROD_W = 2 * DATA_W;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_busy;
    logic [IDX_W-1:0]           r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [DATA_W-1:0]   r_coef [TAPS];
    logic [DATA_W-1:0]          r_out_data;
    logic                       r_out_valid;

    logic                       w_accept;
    logic                       w_acc_clr;
    logic                       w_acc_en;
    logic                       w_done;
    logic                       w_last;
    logic [DATA_W-1:0]          w_tap;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_shifted;
    logic [DATA_W-1:0]          w_out_nxt;

    assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == IDX_W'(TAPS - 1));
    assign busy      = r_busy;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    shift_mac_tapline #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_tapline (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_shift_en (w_accept),
        .i_data     (in_data),
        .i_rd_idx   (r_idx),
        .o_rd_data  (w_tap)
    );

    // State register; busy tracks the next state so it is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_acc_clr   = 1'b1;
                    w_state_nxt = ACC;
                end
            end
            ACC: begin
                w_acc_en = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_prod = $signed(w_tap) * r_coef[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_acc_clr) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_acc_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign w_shifted = r_acc >>> SHIFT;

`ifdef SHIFT_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    always_comb begin
        w_out_nxt = w_shifted[DATA_W-1:0];
`ifdef SHIFT_MAC_SAT_EN
        if (w_shifted > SAT_MAX) begin
            w_out_nxt = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_out_nxt = {1'b1, {(DATA_W-1){1'b0}}};
        end
`endif
    end

    // A DONE in the same cycle as a take keeps out_valid set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_done) begin
            r_out_data  <= w_out_nxt;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
            end
        end else if (coef_we && !r_busy && (32'(coef_addr) < TAPS)) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_shift_mac_fir.sv
// Directed bench for shift_mac_fir; a second instance with SHIFT=1 shares all inputs.
module tb_shift_mac_fir;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [15:0] coef_data;
    logic        busy;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    logic        in_ready2;
    logic        busy2;
    logic [15:0] out_data2;
    logic        out_valid2;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;

    shift_mac_fir #(.DATA_W(16), .TAPS(4), .SHIFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    shift_mac_fir #(.DATA_W(16), .TAPS(4), .SHIFT(1)) u_dut_shr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready)
    );

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        repeat (2) step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic wr_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = 16'(data);
        step;
        coef_we = 1'b0;
    endtask

    task automatic wr_ramp;
        for (int k = 0; k < 4; k++) wr_coef(k, k + 1);
    endtask

    task automatic send(input int x);
        in_data  = 16'(x);
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !in_ready; n++) step;
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        step;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic get(input string tag, input int exp);
        int n = 0;
        while (!out_valid && n < 50) begin
            step;
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, {16'h0, out_data}, {16'h0, 16'(exp)});
        chk({tag, "_lat"}, 32'(cyc - acc_cyc + 1), 32'd6);
    endtask

    task automatic run(input int x, input string tag, input int exp);
        send(x);
        get(tag, exp);
    endtask

    int exp_sat [5];

    initial begin
        out_ready = 1'b1;
        in_data   = '0;
        coef_addr = '0;
        coef_data = '0;
        do_reset;
        chk("rst_ov",   32'(out_valid), 32'd0);
        chk("rst_od",   {16'h0, out_data}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ird",  32'(in_ready), 32'd1);

        // Basic filtering with coefficients 1,2,3,4
        wr_ramp;
        run(100, "ramp0", 100);
        run(10,  "ramp1", 210);
        run(30,  "ramp2", 350);
        run(21,  "ramp3", 511);

        // Full-scale products: saturate or wrap
`ifdef SHIFT_MAC_SAT_EN
        exp_sat = '{32767, 32767, 32767, 32767, 32767};
`else
        exp_sat = '{1, 2, 3, 4, 4};
`endif
        do_reset;
        for (int k = 0; k < 4; k++) wr_coef(k, 32767);
        for (int i = 0; i < 5; i++) run(32767, $sformatf("big%0d", i), exp_sat[i]);

        // Negative result and arithmetic shift
        do_reset;
        wr_coef(0, -1);
        run(101, "neg", -101);
        chk("shr_valid", 32'(out_valid2), 32'd1);
        chk("shr", {16'h0, out_data2}, {16'h0, 16'(-51)});

        // Backpressure: held result, no accept until out_ready rises
        do_reset;
        wr_ramp;
        out_ready = 1'b0;
        run(100, "bp0", 100);
        in_data  = 16'd10;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step;
            chk("bp_ird",  32'(in_ready), 32'd0);
            chk("bp_ov",   32'(out_valid), 32'd1);
            chk("bp_hold", {16'h0, out_data}, 32'd100);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_go", 32'(in_ready), 32'd1);
        run(10, "bp1", 210);

        // Coefficient write during ACC is dropped; write in IDLE lands
        do_reset;
        wr_ramp;
        send(100);
        step;
        chk("cd_busy", 32'(busy), 32'd1);
        wr_coef(0, 9);
        get("cd0", 100);
        run(10, "cd1", 210);
        wr_coef(0, 9);
        run(30, "cd2", 590);

        // Reset in the middle of ACC
        do_reset;
        wr_ramp;
        run(100, "pre", 100);
        send(10);
        step;
        step;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_ov",   32'(out_valid), 32'd0);
        chk("mr_od",   {16'h0, out_data}, 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ird",  32'(in_ready), 32'd1);
        step;
        rst_n = 1'b1;
        repeat (10) step;
        chk("mr_noemit", 32'(out_valid), 32'd0);
        run(21, "mr_zero", 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
